// File: rtl/acia_tx.sv
// ACIA transmitter: 8N1 serial output with a holding register in front of a
// 10-bit shift register, bit timing advanced only on pclk-qualified edges.
module acia_tx #(
  parameter int SCW     = 11,
  parameter int sym_cnt = 1667
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pclk,
  input  logic [7:0] tx_dat,
  input  logic       tx_start,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_active
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SCW-1:0] reload_c = SCW'(sym_cnt - 1);

  state_t         state_r;
  logic [7:0]     hold_r;
  logic [9:0]     shift_r;
  logic [3:0]     bit_cnt_r;
  logic [SCW-1:0] rate_r;
  logic           busy_r;
  logic           active_r;
  logic           last_tick_s;
  logic           load_s;
  logic           accept_s;

  // Transfer and write-accept decisions, all based on pre-edge state.
  always_comb begin
    last_tick_s = (state_r == SHIFT) && (rate_r == {SCW{1'b0}}) && (bit_cnt_r == 4'd0);
    load_s      = pclk && busy_r && ((state_r == IDLE) || last_tick_s);
    accept_s    = tx_start && !busy_r;
  end

  // Holding register, shifter FSM and bit timing; the line idles as all-ones in shift_r.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      hold_r   <= 8'h00;
      shift_r  <= {10{1'b1}};
      active_r <= 1'b0;
    end else begin
      if (load_s) begin
        busy_r <= 1'b0;
      end else if (accept_s) begin
        busy_r <= 1'b1;
        hold_r <= tx_dat;
      end else begin
        busy_r <= busy_r;
      end

      if (load_s) begin
        state_r   <= SHIFT;
        shift_r   <= {1'b1, hold_r, 1'b0};
        bit_cnt_r <= 4'd9;
        rate_r    <= reload_c;
        active_r  <= 1'b1;
      end else if (pclk) begin
        case (state_r)
          IDLE: begin
            shift_r  <= {10{1'b1}};
            active_r <= 1'b0;
          end
          SHIFT: begin
            if (rate_r != {SCW{1'b0}}) begin
              rate_r <= rate_r - SCW'(1);
            end else if (bit_cnt_r != 4'd0) begin
              shift_r   <= {1'b1, shift_r[9:1]};
              bit_cnt_r <= bit_cnt_r - 4'd1;
              rate_r    <= reload_c;
            end else begin
              state_r  <= IDLE;
              shift_r  <= {10{1'b1}};
              active_r <= 1'b0;
            end
          end
          default: begin
            state_r  <= IDLE;
            shift_r  <= {10{1'b1}};
            active_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign tx_serial = shift_r[0];
  assign tx_busy   = busy_r;
  assign tx_active = active_r;

endmodule

// File: tb/tb_acia_tx.sv
// Self-checking bench for acia_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-position reference model.
module tb_acia_tx;
  localparam int SYM = 4;
  localparam int SCW = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pclk;
  logic [7:0] tx_dat;
  logic       tx_start;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_active;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // reference model: pending byte, frame byte and pclk-tick position in frame
  bit       m_full   = 1'b0;
  bit [7:0] m_hold   = 8'h00;
  bit       m_active = 1'b0;
  bit [7:0] m_byte   = 8'h00;
  int       m_pos    = 0;

  int cyc      = 0;
  int pmode    = 0;
  int cur_run  = 0;
  int last_run = 0;

  acia_tx #(.SCW(SCW), .sym_cnt(SYM)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pclk      (pclk),
    .tx_dat    (tx_dat),
    .tx_start  (tx_start),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // line level from position in frame: start, d0..d7, stop; each SYM ticks
  function automatic bit exp_serial();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / SYM;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_edge();
    bit old_full;
    old_full = m_full;
    if (!reset_n) begin
      m_active = 1'b0;
      m_full   = 1'b0;
      return;
    end
    if (pclk && m_active) begin
      m_pos++;
      if (m_pos == 10 * SYM) m_active = 1'b0;
    end
    if (pclk && !m_active && old_full) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_byte   = m_hold;
      m_full   = 1'b0;
    end else if (tx_start && !old_full) begin
      m_full = 1'b1;
      m_hold = tx_dat;
    end
  endtask

  task automatic tick();
    case (pmode)
      0:       pclk = 1'b1;
      1:       pclk = (cyc % 4 == 0);
      default: pclk = ($urandom_range(0, 3) != 0);
    endcase
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("outputs{serial,busy,active}", 32'({tx_serial, tx_busy, tx_active}),
        32'({exp_serial(), m_full, m_active}));
    if (tx_active === 1'b1) cur_run++;
    else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
    end
  endtask

  task automatic write(input logic [7:0] b);
    tx_dat   = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_dat   = 8'($urandom);
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (tx_busy !== 1'b0) chk("busy_fall_timeout", 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((tx_active !== 1'b0 || tx_busy !== 1'b0) && n < budget);
    if (tx_active !== 1'b0 || tx_busy !== 1'b0)
      chk("idle_timeout", 32'({tx_busy, tx_active}), 32'd0);
  endtask

  initial begin
    int low;
    int n;
    reset_n  = 1'b0;
    tx_start = 1'b0;
    tx_dat   = 8'h00;
    pclk     = 1'b0;

    // reset with random pclk
    pmode = 2;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_serial", 32'(tx_serial), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_active", 32'(tx_active), 32'd0);
    reset_n = 1'b1;
    pmode   = 0;
    tick();

    // single byte 0x55
    write(8'h55);
    chk("write_busy", 32'(tx_busy), 32'd1);
    wait_idle(100);
    chk("single_active_len", 32'(last_run), 32'd40);

    // back-to-back
    write(8'hA5);
    wait_busy_low(20);
    write(8'h3C);
    wait_idle(200);
    chk("b2b_active_len", 32'(last_run), 32'd80);

    // overrun: 0xFF must be dropped
    write(8'h11);
    wait_busy_low(20);
    write(8'h22);
    tick();
    chk("overrun_busy", 32'(tx_busy), 32'd1);
    write(8'hFF);
    wait_idle(300);
    chk("overrun_active_len", 32'(last_run), 32'd80);

    // slow pclk, write on a pclk=0 cycle
    pmode = 1;
    while (cyc % 4 == 0) tick();
    write(8'hFF);
    chk("slow_capture_busy", 32'(tx_busy), 32'd1);
    n = 0;
    while (tx_serial !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    low = 0;
    while (tx_serial === 1'b0 && low < 100) begin
      low++;
      tick();
    end
    chk("slow_start_bit_len", 32'(low), 32'd16);
    wait_idle(800);
    chk("slow_active_len", 32'(last_run), 32'd160);
    pmode = 0;

    // reset during bit 3 with holding full
    write(8'h5A);
    wait_busy_low(20);
    write(8'hC3);
    for (int i = 0; i < 12; i++) tick();
    chk("pre_reset_busy", 32'(tx_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midreset_serial", 32'(tx_serial), 32'd1);
    chk("midreset_busy", 32'(tx_busy), 32'd0);
    chk("midreset_active", 32'(tx_active), 32'd0);
    reset_n = 1'b1;
    write(8'h80);
    wait_idle(100);
    chk("post_reset_active_len", 32'(last_run), 32'd40);

    // random traffic, random pclk, rare resets
    pmode = 2;
    for (int i = 0; i < 3000; i++) begin
      tx_start = ($urandom_range(0, 5) == 0);
      tx_dat   = 8'($urandom);
      reset_n  = ($urandom_range(0, 499) != 0);
      tick();
    end
    tx_start = 1'b0;
    reset_n  = 1'b1;
    pmode    = 0;
    wait_idle(200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
